// File: rtl/axis_tlast_framer.sv
// axis_tlast_framer: re-frames an AXI-Stream by programmable length, input tlast or idle timeout.
// One beat is held back in P so a length/tlast boundary can be marked on the beat before it leaves.
module axis_tlast_framer #(
    parameter int DATA_WIDTH_BYTES = 8,
    parameter int MAX_FRAME_BEATS = 256,
    parameter int TIMEOUT_CYCLES = 1024,
    localparam int DW = DATA_WIDTH_BYTES * 8,
    localparam int LW = $clog2(MAX_FRAME_BEATS + 1),
    localparam int TW = TIMEOUT_CYCLES > 1 ? $clog2(TIMEOUT_CYCLES) : 1
) (
    input  logic                        clk,
    input  logic                        arst,
    input  logic [LW-1:0]               frame_len,
    input  logic                        s_axis_tvalid,
    output logic                        s_axis_tready,
    input  logic                        s_axis_tlast,
    input  logic [DW-1:0]               s_axis_tdata,
    input  logic [DATA_WIDTH_BYTES-1:0] s_axis_tkeep,
    output logic                        m_axis_tvalid,
    input  logic                        m_axis_tready,
    output logic                        m_axis_tlast,
    output logic [DW-1:0]               m_axis_tdata,
    output logic [DATA_WIDTH_BYTES-1:0] m_axis_tkeep,
    output logic [31:0]                 frame_count,
    output logic                        timeout_flush
);
    logic [DW-1:0]               p_data;
    logic [DATA_WIDTH_BYTES-1:0] p_keep;
    logic                        p_valid, p_final;
    logic [LW-1:0]               cnt, len_q, len_eff;
    logic [TW-1:0]               to_cnt;
    logic                        o_free, accept, beat_final, to_hit, flush, o_load;

    assign o_free        = !m_axis_tvalid || m_axis_tready;
    assign s_axis_tready = o_free;
    assign accept        = s_axis_tvalid && o_free;
    // the length is sampled only on the first beat of a frame
    assign len_eff    = cnt == '0 ? (frame_len == '0 ? LW'(MAX_FRAME_BEATS) : frame_len) : len_q;
    assign beat_final = s_axis_tlast || (cnt + LW'(1) == len_eff);
    assign to_hit     = TIMEOUT_CYCLES != 0 && to_cnt == TW'(TIMEOUT_CYCLES - 1);
    assign flush      = p_valid && !p_final && !accept && o_free && to_hit;
    assign o_load     = p_valid && o_free && (accept || p_final || flush);

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            m_axis_tvalid <= 1'b0;
            m_axis_tlast  <= 1'b0;
            m_axis_tdata  <= '0;
            m_axis_tkeep  <= '0;
            p_valid       <= 1'b0;
            p_final       <= 1'b0;
            p_data        <= '0;
            p_keep        <= '0;
            cnt           <= '0;
            len_q         <= '0;
            to_cnt        <= '0;
            frame_count   <= '0;
            timeout_flush <= 1'b0;
        end else begin
            if (o_free) begin
                m_axis_tvalid <= o_load;
                m_axis_tlast  <= o_load && (p_final || flush);
                if (o_load) begin
                    m_axis_tdata <= p_data;
                    m_axis_tkeep <= p_keep;
                end
            end
            if (accept) begin
                p_valid <= 1'b1;
                p_final <= beat_final;
                p_data  <= s_axis_tdata;
                p_keep  <= s_axis_tkeep;
                len_q   <= len_eff;
                cnt     <= beat_final ? '0 : cnt + LW'(1);
            end else if (o_load) begin
                p_valid <= 1'b0;
                if (flush) cnt <= '0;
            end
            // saturates while the output is blocked so the flush fires on the first free cycle
            if (accept || !p_valid || p_final) to_cnt <= '0;
            else if (!to_hit) to_cnt <= to_cnt + TW'(1);
            if (m_axis_tvalid && m_axis_tready && m_axis_tlast) frame_count <= frame_count + 32'd1;
            timeout_flush <= flush;
        end
    end
endmodule

// File: tb/tb_axis_tlast_framer.sv
// tb_axis_tlast_framer: directed and randomised checks of the framer with MAX_FRAME_BEATS=4, TIMEOUT_CYCLES=8.
// A scoreboard pairs every accepted beat with the beat that later leaves on m_axis.
module tb_axis_tlast_framer;
    logic        clk = 1'b0;
    logic        arst;
    logic [2:0]  frame_len;
    logic        s_valid, s_ready, s_last;
    logic [63:0] s_data;
    logic [7:0]  s_keep;
    logic        m_valid, m_ready, m_last;
    logic [63:0] m_data;
    logic [7:0]  m_keep;
    logic [31:0] frame_count;
    logic        timeout_flush;

    typedef struct {
        logic [63:0] d;
        logic [7:0]  k;
        logic        l;
    } beat_t;

    beat_t       acc_q[$];
    int          checks = 0, errors = 0;
    int          mpos = 0, mlen = 0, n_out = 0, flush_count = 0;
    logic [31:0] last_hist = '0;
    logic        acc_seen = 1'b0, stall = 1'b0, hl;
    logic [63:0] hd;

    axis_tlast_framer #(.DATA_WIDTH_BYTES(8), .MAX_FRAME_BEATS(4), .TIMEOUT_CYCLES(8)) dut (
        .clk(clk), .arst(arst), .frame_len(frame_len),
        .s_axis_tvalid(s_valid), .s_axis_tready(s_ready), .s_axis_tlast(s_last),
        .s_axis_tdata(s_data), .s_axis_tkeep(s_keep),
        .m_axis_tvalid(m_valid), .m_axis_tready(m_ready), .m_axis_tlast(m_last),
        .m_axis_tdata(m_data), .m_axis_tkeep(m_keep),
        .frame_count(frame_count), .timeout_flush(timeout_flush)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // the held beat will leave as a timeout-closed frame
    task automatic mark_timeout();
        beat_t b;
        b = acc_q.pop_back();
        b.l = 1'b1;
        acc_q.push_back(b);
        mpos = 0;
    endtask

    task automatic tick();
        beat_t e;
        logic  fin;
        #1;
        acc_seen = s_valid && s_ready;
        chk("s_ready", s_ready, !m_valid || m_ready);
        if (stall) begin
            chk("hold_valid", m_valid, 1);
            chk("hold_data", m_data, hd);
            chk("hold_last", m_last, hl);
        end
        stall = m_valid && !m_ready;
        hd = m_data;
        hl = m_last;
        if (timeout_flush) flush_count++;
        if (m_valid && m_ready) begin
            n_out++;
            last_hist = {last_hist[30:0], m_last};
            checks++;
            assert (acc_q.size() != 0) else begin
                errors++;
                $error("FAIL spurious_out: observed data %h with no pending input", m_data);
            end
            if (acc_q.size() != 0) begin
                e = acc_q.pop_front();
                chk("out_data", m_data, e.d);
                chk("out_keep", m_keep, e.k);
                chk("out_last", m_last, e.l);
            end
        end
        if (acc_seen) begin
            if (mpos == 0) mlen = frame_len == 0 ? 4 : int'(frame_len);
            mpos++;
            fin = s_last || mpos == mlen;
            if (fin) mpos = 0;
            acc_q.push_back('{d: s_data, k: s_keep, l: fin});
        end
        @(negedge clk);
    endtask

    task automatic send(input logic [63:0] d, input logic l);
        s_valid = 1'b1;
        s_data  = d;
        s_keep  = ~d[7:0];
        s_last  = l;
        tick();
        chk("accept", acc_seen, 1);
        s_valid = 1'b0;
    endtask

    initial begin
        int n_in, cyc, fc_base;
        arst = 1'b1; frame_len = 3'd4; s_valid = 1'b0; s_last = 1'b0;
        s_data = '0; s_keep = '0; m_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("rst_m_valid", m_valid, 0);
        chk("rst_m_last", m_last, 0);
        chk("rst_s_ready", s_ready, 1);
        chk("rst_frame_count", frame_count, 0);
        chk("rst_flush", timeout_flush, 0);
        arst = 1'b0;

        // length-4 frames, continuous stream
        for (int i = 1; i <= 8; i++) send(64'(i), 1'b0);
        repeat (3) tick();
        chk("len4_last_mask", last_hist[7:0], 8'b0001_0001);
        chk("len4_frames", frame_count, 2);

        // frame_len=0 selects 4; input tlast on beat 2 restarts the count
        frame_len = 3'd0;
        for (int i = 1; i <= 6; i++) send(64'h10 + 64'(i), i == 2);
        repeat (3) tick();
        chk("max_last_mask", last_hist[5:0], 6'b01_0001);
        chk("max_frames", frame_count, 4);

        // three beats then idle: the third leaves 8 cycles after its accept
        for (int i = 1; i <= 3; i++) send(64'h20 + 64'(i), 1'b0);
        fc_base = flush_count;
        repeat (7) tick();
        chk("to_early_valid", m_valid, 0);
        mark_timeout();
        tick();
        chk("to_valid", m_valid, 1);
        chk("to_data", m_data, 64'h23);
        chk("to_last", m_last, 1);
        chk("to_flush", timeout_flush, 1);
        tick();
        chk("to_flush_once", timeout_flush, 0);
        chk("to_pulses", flush_count - fc_base, 1);
        chk("to_frames", frame_count, 5);

        // output stalled for 20 cycles with a partial frame pending
        frame_len = 3'd4;
        for (int i = 1; i <= 3; i++) send(64'h30 + 64'(i), 1'b0);
        m_ready = 1'b0;
        repeat (20) tick();
        chk("stall_s_ready", s_ready, 0);
        chk("stall_data", m_data, 64'h32);
        chk("stall_valid", m_valid, 1);
        m_ready = 1'b1;
        mark_timeout();
        tick();
        chk("stall_flush_data", m_data, 64'h33);
        chk("stall_flush_last", m_last, 1);
        chk("stall_flush", timeout_flush, 1);
        tick();
        chk("stall_drained", m_valid, 0);
        chk("stall_queue", acc_q.size(), 0);
        chk("stall_frames", frame_count, 6);

        // reset mid-frame drops the partial frame
        send(64'h41, 1'b0);
        send(64'h42, 1'b0);
        arst = 1'b1;
        acc_q.delete();
        mpos = 0;
        #1;
        chk("arst_m_valid", m_valid, 0);
        chk("arst_frames", frame_count, 0);
        tick();
        arst = 1'b0;
        for (int i = 1; i <= 4; i++) send(64'h50 + 64'(i), 1'b0);
        repeat (3) tick();
        chk("arst_last_mask", last_hist[3:0], 4'b0001);
        chk("arst_new_frames", frame_count, 1);
        chk("arst_queue", acc_q.size(), 0);

        // random handshakes, 131 beats, final beat carries tlast so nothing is left held
        frame_len = 3'd3;
        fc_base = flush_count;
        n_in = 0;
        cyc = 0;
        while (cyc < 4000 && (n_in < 131 || acc_q.size() != 0)) begin
            if (!s_valid && n_in < 131 && $urandom_range(15) != 0) begin
                s_valid = 1'b1;
                s_data  = {$urandom, $urandom};
                s_keep  = 8'($urandom);
                s_last  = n_in == 130 || $urandom_range(7) == 0;
            end
            m_ready = $urandom_range(7) != 0;
            tick();
            if (acc_seen) begin
                n_in++;
                s_valid = 1'b0;
            end
            cyc++;
        end
        m_ready = 1'b1;
        chk("rand_beats_in", n_in, 131);
        chk("rand_queue", acc_q.size(), 0);
        chk("rand_no_timeout", flush_count - fc_base, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
